// File: rtl/addsub_acc_pkg.sv
// Shared widths and FSM encoding for the add/sub accumulator.
//   WIDTH  - operand width
//   LEN_W  - sequence-length field width
//   ACC_W  - accumulator width (one carry bit above the operand)
package addsub_acc_pkg;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned ACC_W = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_accumulator_core.sv
// Combinational add/subtract step for the accumulator.
//   acc      - current accumulator value
//   operand  - unsigned operand, zero-extended
//   sub      - 1 = acc - operand, 0 = acc + operand
//   next_c   - updated accumulator value (wrapped or saturated)
//   carry_c  - carry out of the top bit (add) or borrow (sub)
// Optional macro ADDSUB_ACC_SAT_EN: saturate instead of wrapping on carry/borrow.
module addsub_core
    import addsub_acc_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  logic             sub,
    output logic [ACC_W-1:0] next_c,
    output logic             carry_c
);

    logic [ACC_W:0] ext;

    // One extra bit: set on carry for add, and on borrow (negative) for sub.
    always_comb begin
        ext = '0;
        if (sub) begin
            ext = {1'b0, acc} - (ACC_W + 1)'(operand);
        end else begin
            ext = {1'b0, acc} + (ACC_W + 1)'(operand);
        end
        carry_c = ext[ACC_W];
`ifdef ADDSUB_ACC_SAT_EN
        if (ext[ACC_W]) begin
            next_c = sub ? '0 : '1;
        end else begin
            next_c = ext[ACC_W-1:0];
        end
`else
        next_c = ext[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/addsub_accumulator.sv
// Folds a programmed-length stream of add/sub operands into a registered
// accumulator and hands the result plus a sticky overflow flag to a consumer.
//   clk, rst            - clock, asynchronous active-high reset
//   start, len          - begin a sequence of len operands (IDLE only)
//   in_valid/in_ready   - operand handshake; in_data operand, in_sub select
//   out_valid/out_ready - result handshake; result, ovf
//   busy                - sequence in progress
// Optional macro ADDSUB_ACC_SAT_EN: saturate on overflow instead of wrapping.
module addsub_accumulator
    import addsub_acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             ovf,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] core_next;
    logic             core_carry;

    addsub_core u_core (
        .acc     (acc_q),
        .operand (in_data),
        .sub     (in_sub),
        .next_c  (core_next),
        .carry_c (core_carry)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        count_d = len;
                        state_d = ACCUM;
                    end else begin
                        state_d = REPORT;
                    end
                end
            end
            ACCUM: begin
                if (in_valid && in_ready) begin
                    acc_d   = core_next;
                    ovf_d   = ovf_q | core_carry;
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; handshake flags are registered decodes of next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            count_q   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
            in_ready  <= (state_d == ACCUM);
            out_valid <= (state_d == REPORT);
            busy      <= (state_d != IDLE);
        end
    end

    assign result = acc_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Self-checking bench for addsub_accumulator: expected {ovf,result} pairs are
// queued when a sequence is driven and compared when the DUT reports.
module tb_addsub_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] result;
    logic       ovf;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [5:0] sb[$];  // {ovf, result}

    int m_acc;
    bit m_ovf;

    addsub_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic for a 5-bit accumulator.
    task automatic model_step(input int d, input bit s);
        if (s) begin
            if (m_acc < d) begin
                m_ovf = 1'b1;
`ifdef ADDSUB_ACC_SAT_EN
                m_acc = 0;
`else
                m_acc = m_acc - d + 32;
`endif
            end else begin
                m_acc = m_acc - d;
            end
        end else begin
            if (m_acc + d > 31) begin
                m_ovf = 1'b1;
`ifdef ADDSUB_ACC_SAT_EN
                m_acc = 31;
`else
                m_acc = m_acc + d - 32;
`endif
            end else begin
                m_acc = m_acc + d;
            end
        end
    endtask

    task automatic start_seq(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = 4'd0;
    endtask

    // Present one operand and wait (bounded) until it is accepted.
    task automatic feed(input logic [3:0] d, input logic s);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout in_ready=%b required 1", in_ready);
        end
        tick();
    endtask

    // Wait for a result, compare against the scoreboard, then take it.
    task automatic collect(input string name);
        logic [5:0] exp;
        int n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_out_valid got=%b exp=1", name, out_valid);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard_empty got=0 exp=1 entries", name);
            exp = '0;
        end else begin
            exp = sb.pop_front();
        end
        checks++;
        if (result !== exp[4:0]) begin
            errors++;
            $display("FAIL %s_result got=%b exp=%b", name, result, exp[4:0]);
        end
        checks++;
        if (ovf !== exp[5]) begin
            errors++;
            $display("FAIL %s_ovf got=%b exp=%b", name, ovf, exp[5]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_release out_valid=%b busy=%b exp 0 0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, in_ready, out_valid, result, ovf} !== 9'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b in_ready=%b out_valid=%b result=%b ovf=%b exp all 0",
                     busy, in_ready, out_valid, result, ovf);
        end
        rst = 1'b0;
        tick();
        // Operand offered in IDLE must not be taken.
        in_valid = 1'b1;
        in_data  = 4'd7;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0 || result !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_in_valid in_ready=%b result=%b busy=%b exp 0 00000 0",
                     in_ready, result, busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        start_seq(4'd3);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_accum_entry busy=%b in_ready=%b exp 1 1", busy, in_ready);
        end
        sb.push_back({1'b0, 5'b00110});
        feed(4'b0101, 1'b0);
        feed(4'b0011, 1'b0);
        feed(4'b0010, 1'b1);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency out_valid=%b in_ready=%b exp 1 0", out_valid, in_ready);
        end
        collect("basic");
    endtask

    task automatic test_wrap();
        start_seq(4'd3);
`ifdef ADDSUB_ACC_SAT_EN
        sb.push_back({1'b1, 5'b11111});
`else
        sb.push_back({1'b1, 5'b01101});
`endif
        for (int i = 0; i < 3; i++) feed(4'b1111, 1'b0);
        in_valid = 1'b0;
        collect("wrap");
    endtask

    task automatic test_borrow();
        start_seq(4'd1);
`ifdef ADDSUB_ACC_SAT_EN
        sb.push_back({1'b1, 5'b00000});
`else
        sb.push_back({1'b1, 5'b11111});
`endif
        feed(4'b0001, 1'b1);
        in_valid = 1'b0;
        collect("borrow");
    endtask

    task automatic test_zero_len();
        start_seq(4'd0);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_report out_valid=%b in_ready=%b exp 1 0", out_valid, in_ready);
        end
        sb.push_back({1'b0, 5'b00000});
        collect("zero_len");
    endtask

    task automatic test_backpressure();
        logic [5:0] exp;
        start_seq(4'd2);
        feed(4'd7, 1'b0);
        feed(4'd3, 1'b0);
        in_valid = 1'b0;
        exp = {1'b0, 5'd10};
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 4'd5;
            tick();
            start = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || result !== exp[4:0] || ovf !== exp[5]) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d out_valid=%b result=%b ovf=%b exp 1 %b %b",
                         i, out_valid, result, ovf, exp[4:0], exp[5]);
            end
        end
        len = 4'd0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release busy=%b out_valid=%b exp 0 0", busy, out_valid);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_start_ignored busy=%b in_ready=%b exp 0 0", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        start_seq(4'd4);
        feed(4'd5, 1'b0);
        feed(4'd6, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || result !== 5'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid busy=%b in_ready=%b result=%b ovf=%b exp 0 0 00000 0",
                     busy, in_ready, result, ovf);
        end
        tick();
        rst = 1'b0;
        tick();
        start_seq(4'd1);
        sb.push_back({1'b0, 5'd9});
        feed(4'd9, 1'b0);
        in_valid = 1'b0;
        collect("after_reset");
    endtask

    task automatic test_back_to_back();
        for (int seq = 0; seq < 5; seq++) begin
            int l;
            l = $urandom_range(1, 8);
            m_acc = 0;
            m_ovf = 1'b0;
            start_seq(4'(l));
            for (int k = 0; k < l; k++) begin
                logic [3:0] d;
                logic s;
                d = 4'($urandom_range(0, 15));
                s = 1'($urandom_range(0, 1));
                model_step(int'(d), s);
                feed(d, s);
            end
            in_valid = 1'b0;
            sb.push_back({m_ovf, 5'(m_acc)});
            collect($sformatf("b2b%0d", seq));
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_wrap();
        test_borrow();
        test_zero_len();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
